mux_striping: RTL and testbench



---
 rtl/mux_striping_pkg.sv | 24 ++
 rtl/mux_striping_if.sv | 37 +++
 rtl/mux_striping_lane_fifo.sv | 65 ++++++
 rtl/mux_striping.sv | 132 +++++++++++++
 tb/tb_mux_striping.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_striping_pkg.sv
// Shared definitions for the mux_striping unstriping receiver: default
// widths, the lane pointer encoding and the pointer-width helper.
package mux_striping_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    // Which lane the output pointer is waiting on next.
    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    // Ceiling log2, used for FIFO pointer and occupancy widths.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_striping_if.sv
// Lane inputs and reassembled output of mux_striping.
// err_overflow exists only when MUX_STRIPING_ERR_EN is defined.
interface mux_striping_if
    import mux_striping_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] data_in0;
    logic              valid_in0;
    logic [DATA_W-1:0] data_in1;
    logic              valid_in1;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
`ifdef MUX_STRIPING_ERR_EN
    logic              err_overflow;

    modport master (
        output data_in0, valid_in0, data_in1, valid_in1,
        input  data_out, valid_out, err_overflow
    );

    modport slave (
        input  data_in0, valid_in0, data_in1, valid_in1,
        output data_out, valid_out, err_overflow
    );
`else
    modport master (
        output data_in0, valid_in0, data_in1, valid_in1,
        input  data_out, valid_out
    );

    modport slave (
        input  data_in0, valid_in0, data_in1, valid_in1,
        output data_out, valid_out
    );
`endif
endinterface

// File: rtl/mux_striping_lane_fifo.sv
// lane_fifo: per-lane elastic buffer absorbing inter-lane skew.
// Head word is presented combinationally on dout. A push into a full FIFO
// is dropped unless a pop happens on the same edge; the drop is flagged by
// a one-cycle overflow pulse.
module lane_fifo
    import mux_striping_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              overflow
);
    localparam int PTR_W = clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign dout     = mem[rd_ptr];

    // Storage write; only pointers and count define which entries are live.
    // NOTE: the data array has no reset -- stale entries are never read
    // because empty gates every pop, and a reset on it would cost a mux per bit.
    always_ff @(posedge clk_f) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/mux_striping.sv
// mux_striping: rebuilds a single word stream from two striped lanes,
// strictly alternating lane 0, lane 1, lane 0, ... Each lane is buffered in
// a lane_fifo; this module holds only the lane pointer FSM and the
// registered output.
// Optional feature: define MUX_STRIPING_ERR_EN to add the sticky
// err_overflow flag, set on any dropped push on either lane.
module mux_striping
    import mux_striping_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic          clk_f,
    input  logic          reset,
    mux_striping_if.slave bus
);
    logic [DATA_W-1:0] dout0;
    logic [DATA_W-1:0] dout1;
    logic              full0;
    logic              full1;
    logic              empty0;
    logic              empty1;
    logic              ovf0;
    logic              ovf1;
    logic              pop0;
    logic              pop1;
    lane_e             state_q;
    lane_e             state_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk_f    (clk_f),
        .reset    (reset),
        .push     (bus.valid_in0),
        .pop      (pop0),
        .din      (bus.data_in0),
        .dout     (dout0),
        .full     (full0),
        .empty    (empty0),
        .overflow (ovf0)
    );

    lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk_f    (clk_f),
        .reset    (reset),
        .push     (bus.valid_in1),
        .pop      (pop1),
        .din      (bus.data_in1),
        .dout     (dout1),
        .full     (full1),
        .empty    (empty1),
        .overflow (ovf1)
    );

    // Lane pointer register.
    // NOTE: clocked blocks use <= so every register samples pre-edge values;
    // blocking = here would make results depend on process order.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q <= LANE0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next lane and pop selection: pop the selected lane only when it has a word.
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pop0    = 1'b0;
        pop1    = 1'b0;
        case (state_q)
            LANE0: begin
                if (!empty0) begin
                    pop0    = 1'b1;
                    state_d = LANE1;
                end
            end
            LANE1: begin
                if (!empty1) begin
                    pop1    = 1'b1;
                    state_d = LANE0;
                end
            end
        endcase
    end

    // Output register: capture the popped head, otherwise drive zero.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (pop0) begin
            data_q  <= dout0;
            valid_q <= 1'b1;
        end else if (pop1) begin
            data_q  <= dout1;
            valid_q <= 1'b1;
        end else begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;

`ifdef MUX_STRIPING_ERR_EN
    logic err_q;
    logic full_unused;

    // Sticky overflow flag: any dropped push on either lane, cleared only by reset.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (ovf0 || ovf1) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_overflow = err_q;
    assign full_unused      = full0 | full1;
`else
    logic ovf_unused;

    // Without the error feature, drops are silent; the pulses go nowhere.
    assign ovf_unused = ovf0 | ovf1 | full0 | full1;
`endif

endmodule

// File: tb/tb_mux_striping.sv
// Self-checking bench for mux_striping (DATA_W = 32, FIFO_DEPTH = 4).
// Stimulus pushes the hand-computed output order into a scoreboard queue;
// an independent monitor pops and compares on every valid output.
// err_overflow checks are compiled in only with MUX_STRIPING_ERR_EN.
module tb_mux_striping;

    logic clk_f = 1'b0;
    logic reset = 1'b1;

    int errors = 0;
    int checks = 0;
    logic [31:0] expq[$];

    always #5 clk_f = ~clk_f;

    mux_striping_if #(.DATA_W(32)) bus ();

    mux_striping #(.DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk_f (clk_f),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every valid output against the scoreboard; zero data when idle.
    always @(negedge clk_f) begin
        if (bus.valid_out === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h, expected no output", bus.data_out);
            end else begin
                check("data_out", bus.data_out, expq.pop_front());
            end
        end else begin
            check("idle_data_zero", bus.data_out, 32'h0);
        end
    end

    // Drive one cycle of lane inputs, sampled at the next rising edge.
    task automatic step(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
        @(negedge clk_f);
        bus.valid_in0 = v0;
        bus.data_in0  = d0;
        bus.valid_in1 = v1;
        bus.data_in1  = d1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Wait (bounded) for the scoreboard to empty, then idle to catch stray words.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 40) begin
            idle();
            n++;
        end
        repeat (3) idle();
        check(name, 32'(expq.size()), 32'h0);
        expq.delete();
    endtask

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
    } vec_t;

    initial begin
        vec_t fullpop [17];

        bus.valid_in0 = 1'b0;
        bus.data_in0  = '0;
        bus.valid_in1 = 1'b0;
        bus.data_in1  = '0;

        // Reset state, before any clock edge.
        #3;
        check("reset_valid", 32'(bus.valid_out), 32'h0);
        check("reset_data", bus.data_out, 32'h0);
`ifdef MUX_STRIPING_ERR_EN
        check("reset_err", 32'(bus.err_overflow), 32'h0);
`endif
        repeat (2) @(negedge clk_f);
        reset = 1'b0;
        repeat (3) begin
            idle();
            check("post_reset_idle", 32'(bus.valid_out), 32'h0);
        end

        // Aligned stream: first valid one cycle after the first sample.
        expq.push_back(32'hA0); expq.push_back(32'hB0);
        expq.push_back(32'hA1); expq.push_back(32'hB1);
        step(1'b1, 32'hA0, 1'b1, 32'hB0);
        step(1'b1, 32'hA1, 1'b1, 32'hB1);
        check("aligned_lat0", 32'(bus.valid_out), 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle();
            check("aligned_valid_run", 32'(bus.valid_out), 32'h1);
        end
        idle();
        check("aligned_end", 32'(bus.valid_out), 32'h0);
        drain("aligned_drain");

        // Lane 1 leads by three words: no output until lane 0 arrives.
        expq.push_back(32'hA0); expq.push_back(32'hB0);
        expq.push_back(32'hA1); expq.push_back(32'hB1);
        expq.push_back(32'hA2); expq.push_back(32'hB2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 32'hB0 + 32'(i));
            check("skew_stall", 32'(bus.valid_out), 32'h0);
        end
        step(1'b1, 32'hA0, 1'b0, 32'h0);
        check("skew_stall", 32'(bus.valid_out), 32'h0);
        step(1'b1, 32'hA1, 1'b0, 32'h0);
        check("skew_wait_a0", 32'(bus.valid_out), 32'h0);
        step(1'b1, 32'hA2, 1'b0, 32'h0);
        check("skew_first_valid", 32'(bus.valid_out), 32'h1);
        drain("skew_drain");

        // Lane 0 FIFO held full while pushing and popping on the same edge.
        fullpop[0]  = '{1'b1, 32'h20, 1'b0, 32'h0};
        fullpop[1]  = '{1'b1, 32'h21, 1'b0, 32'h0};
        fullpop[2]  = '{1'b1, 32'h22, 1'b0, 32'h0};
        fullpop[3]  = '{1'b1, 32'h23, 1'b0, 32'h0};
        fullpop[4]  = '{1'b1, 32'h24, 1'b0, 32'h0};
        fullpop[5]  = '{1'b0, 32'h0,  1'b1, 32'h30};
        fullpop[6]  = '{1'b0, 32'h0,  1'b0, 32'h0};
        fullpop[7]  = '{1'b1, 32'h25, 1'b1, 32'h31};
        fullpop[8]  = '{1'b0, 32'h0,  1'b0, 32'h0};
        fullpop[9]  = '{1'b1, 32'h26, 1'b1, 32'h32};
        fullpop[10] = '{1'b0, 32'h0,  1'b0, 32'h0};
        fullpop[11] = '{1'b1, 32'h27, 1'b1, 32'h33};
        fullpop[12] = '{1'b0, 32'h0,  1'b0, 32'h0};
        fullpop[13] = '{1'b0, 32'h0,  1'b1, 32'h34};
        fullpop[14] = '{1'b0, 32'h0,  1'b1, 32'h35};
        fullpop[15] = '{1'b0, 32'h0,  1'b1, 32'h36};
        fullpop[16] = '{1'b0, 32'h0,  1'b1, 32'h37};
        for (int i = 0; i < 8; i++) begin
            expq.push_back(32'h20 + 32'(i));
            expq.push_back(32'h30 + 32'(i));
        end
        for (int i = 0; i < 17; i++) begin
            step(fullpop[i].v0, fullpop[i].d0, fullpop[i].v1, fullpop[i].d1);
        end
        drain("fullpop_drain");
`ifdef MUX_STRIPING_ERR_EN
        check("fullpop_no_err", 32'(bus.err_overflow), 32'h0);
`endif

        // Overflow: five words on lane 1 with lane 0 idle; the fifth is dropped.
        expq.push_back(32'h10); expq.push_back(32'hB0);
        expq.push_back(32'h11); expq.push_back(32'hB1);
        expq.push_back(32'h12); expq.push_back(32'hB2);
        expq.push_back(32'h13); expq.push_back(32'hB3);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b1, 32'hB0 + 32'(i));
            check("ovf_no_output", 32'(bus.valid_out), 32'h0);
        end
`ifdef MUX_STRIPING_ERR_EN
        check("ovf_err_before", 32'(bus.err_overflow), 32'h0);
`endif
        idle();
`ifdef MUX_STRIPING_ERR_EN
        check("ovf_err_set", 32'(bus.err_overflow), 32'h1);
`endif
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h10 + 32'(i), 1'b0, 32'h0);
        end
        drain("ovf_drain");
`ifdef MUX_STRIPING_ERR_EN
        check("ovf_err_sticky", 32'(bus.err_overflow), 32'h1);
`endif

        // Reset mid-stream with two words buffered per lane.
        expq.push_back(32'h50); expq.push_back(32'h60);
        step(1'b1, 32'h50, 1'b1, 32'h60);
        step(1'b1, 32'h51, 1'b1, 32'h61);
        step(1'b1, 32'h52, 1'b1, 32'h62);
        idle();
        check("pre_reset_valid", 32'(bus.valid_out), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("async_reset_valid", 32'(bus.valid_out), 32'h0);
        check("async_reset_data", bus.data_out, 32'h0);
`ifdef MUX_STRIPING_ERR_EN
        check("async_reset_err", 32'(bus.err_overflow), 32'h0);
`endif
        check("pre_reset_words_seen", 32'(expq.size()), 32'h0);
        expq.delete();
        @(negedge clk_f);
        reset = 1'b0;
        repeat (3) begin
            idle();
            check("reset_discard_idle", 32'(bus.valid_out), 32'h0);
        end
        expq.push_back(32'hC0); expq.push_back(32'hD0);
        step(1'b1, 32'hC0, 1'b1, 32'hD0);
        drain("reset_restart_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
